// File: rtl/sm_addsub_seq.sv
// Sequential signed-magnitude adder/subtractor: converts to two's complement, adds, converts back.
// Define SM_ADDSUB_LZC_EN to add the res_lzc leading-zero-count output.
`timescale 1ns/1ps
module sm_addsub_seq #(
  parameter int W         = 53,
  parameter bit ZERO_SIGN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_mag,
  input  logic         a_sign,
  input  logic [W-1:0] b_mag,
  input  logic         b_sign,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   res_mag,
  output logic         res_sign,
  output logic         res_zero,
  output logic         res_carry
`ifdef SM_ADDSUB_LZC_EN
  ,
  output logic [$clog2(W+2)-1:0] res_lzc
`endif
);

  // Two guard bits: one for the magnitude carry, one for the sign.
  localparam int E = W + 2;

  typedef enum logic [2:0] {IDLE, CONV, ADD, FIX, DONE} state_t;

  state_t         state_reg, state_next;
  logic [E-1:0]   ea_reg, eb_reg, s_reg;
  logic           sa_reg, sb_reg;
  logic [W:0]     fix_mag;
  logic           fix_zero;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CONV;
      CONV:    state_next = ADD;
      ADD:     state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // The low W+1 bits of -s equal the negation of s's low W+1 bits, and the
  // magnitude never needs bit W+1, so only the sign bit is taken from the top.
  always_comb begin
    fix_mag  = s_reg[E-1] ? -s_reg[W:0] : s_reg[W:0];
    fix_zero = (fix_mag == '0);
  end

`ifdef SM_ADDSUB_LZC_EN
  function automatic logic [$clog2(W+2)-1:0] count_lz(input logic [W:0] v);
    int n;
    n = W + 1;
    for (int i = 0; i <= W; i++)
      if (v[i]) n = W - i;
    return ($clog2(W+2))'(n);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ea_reg    <= '0;
      eb_reg    <= '0;
      s_reg     <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      res_mag   <= '0;
      res_sign  <= 1'b0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
`ifdef SM_ADDSUB_LZC_EN
      res_lzc   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ea_reg <= {2'b00, a_mag};
            eb_reg <= {2'b00, b_mag};
            sa_reg <= a_sign;
            sb_reg <= b_sign ^ sub;
          end
        end
        CONV: begin
          ea_reg <= sa_reg ? -ea_reg : ea_reg;
          eb_reg <= sb_reg ? -eb_reg : eb_reg;
        end
        ADD: s_reg <= ea_reg + eb_reg;
        FIX: begin
          res_mag   <= fix_mag;
          res_sign  <= fix_zero ? ZERO_SIGN : s_reg[E-1];
          res_zero  <= fix_zero;
          res_carry <= fix_mag[W];
`ifdef SM_ADDSUB_LZC_EN
          res_lzc   <= count_lz(fix_mag);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Bench for sm_addsub_seq: two W=8 instances (ZERO_SIGN 0/1) and one W=53 instance share handshakes.
// An integer reference model predicts every output each cycle; directed cases also pin literal values.
`timescale 1ns/1ps
module tb_sm_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, a_sign, b_sign, sub;
  logic [52:0] a_mag, b_mag;

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [8:0]  rm0, rm1;
  logic [53:0] rm2;
  logic        rs0, rs1, rs2, rz0, rz1, rz2, rc0, rc1, rc2;
  logic [7:0]  lzv0, lzv1, lzv2;

`ifdef SM_ADDSUB_LZC_EN
  logic [3:0] lz0, lz1;
  logic [5:0] lz2;
  assign lzv0 = 8'(lz0);
  assign lzv1 = 8'(lz1);
  assign lzv2 = 8'(lz2);
`else
  assign lzv0 = 8'd0;
  assign lzv1 = 8'd0;
  assign lzv2 = 8'd0;
`endif

  sm_addsub_seq #(.W(8), .ZERO_SIGN(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a_mag(a_mag[7:0]), .a_sign(a_sign), .b_mag(b_mag[7:0]), .b_sign(b_sign), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready),
    .res_mag(rm0), .res_sign(rs0), .res_zero(rz0), .res_carry(rc0)
`ifdef SM_ADDSUB_LZC_EN
    , .res_lzc(lz0)
`endif
  );

  sm_addsub_seq #(.W(8), .ZERO_SIGN(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a_mag(a_mag[7:0]), .a_sign(a_sign), .b_mag(b_mag[7:0]), .b_sign(b_sign), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready),
    .res_mag(rm1), .res_sign(rs1), .res_zero(rz1), .res_carry(rc1)
`ifdef SM_ADDSUB_LZC_EN
    , .res_lzc(lz1)
`endif
  );

  sm_addsub_seq #(.W(53), .ZERO_SIGN(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a_mag(a_mag), .a_sign(a_sign), .b_mag(b_mag), .b_sign(b_sign), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready),
    .res_mag(rm2), .res_sign(rs2), .res_zero(rz2), .res_carry(rc2)
`ifdef SM_ADDSUB_LZC_EN
    , .res_lzc(lz2)
`endif
  );

  typedef struct packed {
    logic [63:0] mag;
    logic        sign;
    logic        zero;
    logic        carry;
    logic [7:0]  lzc;
  } res_t;

  res_t exp_r [3];
  bit   busy = 1'b0, fresh = 1'b0, started = 1'b0;
  int   age = 0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Signed-integer reference: result value, then its sign/magnitude view.
  function automatic res_t ref_calc(input longint a, input bit sa, input longint b,
                                    input bit sb, input int w, input bit zs);
    res_t   r;
    longint v, m;
    int     lz;
    v = (sa ? -a : a) + (sb ? -b : b);
    m = (v < 0) ? -v : v;
    r.mag   = 64'(m);
    r.zero  = (m == 0);
    r.sign  = (m == 0) ? zs : (v < 0);
    r.carry = (m >= (longint'(1) << w));
    lz = 0;
    while (lz <= w && (m >> (w - lz)) == 0) lz++;
    r.lzc = 8'(lz);
    return r;
  endfunction

  // Transaction-level model: idle/busy, three cycles of work, then hold until taken.
  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; age = 0; fresh = 1'b1; started = 1'b1;
      for (int k = 0; k < 3; k++) exp_r[k] = '0;
    end else if (!busy) begin
      if (in_valid) begin
        busy = 1'b1; age = 0; fresh = 1'b0;
        exp_r[0] = ref_calc(longint'(a_mag[7:0]), a_sign, longint'(b_mag[7:0]), b_sign ^ sub, 8, 1'b0);
        exp_r[1] = ref_calc(longint'(a_mag[7:0]), a_sign, longint'(b_mag[7:0]), b_sign ^ sub, 8, 1'b1);
        exp_r[2] = ref_calc(longint'(a_mag), a_sign, longint'(b_mag), b_sign ^ sub, 53, 1'b0);
      end
    end else if (age == 3) begin
      if (out_ready) busy = 1'b0;
    end else begin
      age++;
    end
  end

  task automatic check_inst(input int k, input logic ir, input logic ov, input logic [63:0] m,
                            input logic s, input logic z, input logic c, input logic [7:0] lz);
    bit exp_ov;
    exp_ov = busy && (age == 3);
    chk($sformatf("u%0d.in_ready", k), 64'(ir), 64'(!busy));
    chk($sformatf("u%0d.out_valid", k), 64'(ov), 64'(exp_ov));
    if (exp_ov || fresh) begin
      chk($sformatf("u%0d.res_mag", k), m, exp_r[k].mag);
      chk($sformatf("u%0d.res_sign", k), 64'(s), 64'(exp_r[k].sign));
      chk($sformatf("u%0d.res_zero", k), 64'(z), 64'(exp_r[k].zero));
      chk($sformatf("u%0d.res_carry", k), 64'(c), 64'(exp_r[k].carry));
`ifdef SM_ADDSUB_LZC_EN
      chk($sformatf("u%0d.res_lzc", k), 64'(lz), 64'(exp_r[k].lzc));
`else
      if (lz != 8'd0) chk($sformatf("u%0d.lzc_tie", k), 64'(lz), 64'd0);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, ir0, ov0, 64'(rm0), rs0, rz0, rc0, lzv0);
      check_inst(1, ir1, ov1, 64'(rm1), rs1, rz1, rc1, lzv1);
      check_inst(2, ir2, ov2, 64'(rm2), rs2, rz2, rc2, lzv2);
    end
  end

  // Present one operand set for a single accept cycle, then scramble the inputs.
  task automatic op(input longint a, input bit sa, input longint b, input bit sb, input bit sbt);
    a_mag = 53'(a); a_sign = sa; b_mag = 53'(b); b_sign = sb; sub = sbt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a_mag = '1; b_mag = '1; a_sign = ~sa; b_sign = ~sb; sub = ~sbt;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 8 && !ov0; i++) @(negedge clk);
    chk("wait_out_valid", 64'(ov0), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_mag = '0; b_mag = '0; a_sign = 1'b0; b_sign = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(ir0), 64'd1);
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_res_mag", 64'(rm0), 64'd0);

    // 200 + 100 = 300, overflows 8 bits into res_carry
    op(200, 1'b0, 100, 1'b0, 1'b0);
    wait_ov();
    chk("add_mag", 64'(rm0), 64'd300);
    chk("add_carry", 64'(rc0), 64'd1);
    chk("add_sign", 64'(rs0), 64'd0);
`ifdef SM_ADDSUB_LZC_EN
    chk("add_lzc", 64'(lz0), 64'd0);
`endif
    @(negedge clk);

    // 50 - 80 = -30
    op(50, 1'b0, 80, 1'b0, 1'b1);
    wait_ov();
    chk("sub_mag", 64'(rm0), 64'd30);
    chk("sub_sign", 64'(rs0), 64'd1);
    chk("sub_carry", 64'(rc0), 64'd0);
`ifdef SM_ADDSUB_LZC_EN
    chk("sub_lzc", 64'(lz0), 64'd4);
`endif
    @(negedge clk);

    // -70 + 70 = 0, sign follows ZERO_SIGN
    op(70, 1'b1, 70, 1'b0, 1'b0);
    wait_ov();
    chk("zero_mag", 64'(rm0), 64'd0);
    chk("zero_flag", 64'(rz0), 64'd1);
    chk("zero_sign_zs0", 64'(rs0), 64'd0);
    chk("zero_sign_zs1", 64'(rs1), 64'd1);
    @(negedge clk);

    // -255 + -255 = -510 held under backpressure
    out_ready = 1'b0;
    op(255, 1'b1, 255, 1'b1, 1'b0);
    wait_ov();
    chk("bp_mag", 64'(rm0), 64'd510);
    chk("bp_sign", 64'(rs0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(negedge clk);
      chk("bp_hold_valid", 64'(ov0), 64'd1);
      chk("bp_hold_ready", 64'(ir0), 64'd0);
      chk("bp_hold_mag", 64'(rm0), 64'd510);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(ov0), 64'd0);
    chk("bp_release_ready", 64'(ir0), 64'd1);

    // Reset while in CONV discards the operation
    op(10, 1'b1, 3, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 64'(ir0), 64'd1);
    chk("midrst_valid", 64'(ov0), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 64'(ov0), 64'd0);
    end
    op(10, 1'b1, 3, 1'b0, 1'b1);
    wait_ov();
    chk("postrst_mag", 64'(rm0), 64'd13);
    chk("postrst_sign", 64'(rs0), 64'd1);
    @(negedge clk);

    // Back-to-back random W=53 operand sets with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_mag  = 53'({$urandom, $urandom});
      b_mag  = 53'({$urandom, $urandom});
      a_sign = 1'($urandom);
      b_sign = 1'($urandom);
      sub    = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
